// File: rtl/lain_axi_pkg.sv
// Shared AXI types and constants for the lain on-chip interconnect blocks.
// The read/write engine state types also live here so every responder decodes them the same way.
package lain_axi_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;
    localparam int AXI_LEN_W  = 8;
    localparam int AXI_SIZE_W = 3;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

    // Reserved burst encoding, or a WRAP whose length is not 2/4/8/16 beats.
    function automatic logic burst_illegal(input logic [1:0] burst, input logic [AXI_LEN_W-1:0] len);
        return (burst == 2'b11) ||
               ((burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat byte address for an AXI burst, plus a flag for illegal burst/length combinations.
// Purely combinational; one copy per channel.
module axi_burst_addr_gen
    import lain_axi_pkg::*;
(
    input  logic [AXI_ADDR_W-1:0] i_addr,
    input  logic [AXI_SIZE_W-1:0] i_size,
    input  logic [AXI_LEN_W-1:0]  i_len,
    input  logic [1:0]            i_burst,
    output logic [AXI_ADDR_W-1:0] o_next_addr,
    output logic                  o_burst_err
);

    logic [AXI_ADDR_W-1:0] w_incr;
    logic [AXI_ADDR_W-1:0] w_span;
    logic [AXI_ADDR_W-1:0] w_mask;
    logic [AXI_ADDR_W-1:0] w_seq;

    always_comb begin
        w_incr = 32'd1 << i_size;
        w_span = ({24'd0, i_len} + 32'd1) << i_size;
        w_mask = w_span - 32'd1;
        w_seq  = i_addr + w_incr;
        o_next_addr = i_addr;
        case (i_burst)
            BURST_FIXED: o_next_addr = i_addr;
            BURST_INCR:  o_next_addr = w_seq;
            // Upper bits pin the aligned wrap block, lower bits roll over inside it
            BURST_WRAP:  o_next_addr = (i_addr & ~w_mask) | (w_seq & w_mask);
            default:     o_next_addr = i_addr;
        endcase
    end

    assign o_burst_err = burst_illegal(i_burst, i_len);

endmodule

// File: rtl/axi_sram_responder.sv
// AXI4 responder in front of a word-addressed flop RAM with independent read and write engines.
// Write engine: W_IDLE | waiting for AW ; W_DATA | accepting W beats ; W_RESP | presenting B until bready
// Read engine:  R_IDLE | waiting for AR ; R_DATA | presenting R beats, one per cycle while rready
module axi_sram_responder
    import lain_axi_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h1c00_0000,
    parameter int          ID_WIDTH  = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [AXI_ADDR_W-1:0] awaddr,
    input  logic [AXI_LEN_W-1:0]  awlen,
    input  logic [AXI_SIZE_W-1:0] awsize,
    input  logic [1:0]            awburst,
    input  logic                  awlock,
    input  logic [3:0]            awcache,
    input  logic [2:0]            awprot,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [AXI_DATA_W-1:0] wdata,
    input  logic [AXI_STRB_W-1:0] wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_WIDTH-1:0]   bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [AXI_ADDR_W-1:0] araddr,
    input  logic [AXI_LEN_W-1:0]  arlen,
    input  logic [AXI_SIZE_W-1:0] arsize,
    input  logic [1:0]            arburst,
    input  logic                  arlock,
    input  logic [3:0]            arcache,
    input  logic [2:0]            arprot,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [AXI_DATA_W-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int          IDX_W      = $clog2(DEPTH);
    localparam logic [32:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

    function automatic logic addr_ok(input logic [AXI_ADDR_W-1:0] a);
        return (a >= BASE_ADDR) && ({1'b0, a} < ADDR_LIMIT);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    logic w_unused;
    assign w_unused = &{1'b0, awlock, awcache, awprot, arlock, arcache, arprot};

    logic [AXI_DATA_W-1:0] r_mem [DEPTH];

    // ------------------------------------------------------------------ write engine
    wstate_e               r_wstate;
    logic [ID_WIDTH-1:0]   r_aw_id;
    logic [AXI_ADDR_W-1:0] r_aw_addr;
    logic [AXI_LEN_W-1:0]  r_aw_len;
    logic [AXI_SIZE_W-1:0] r_aw_size;
    logic [1:0]            r_aw_burst;
    logic [AXI_LEN_W-1:0]  r_wcnt;
    logic                  r_w_err;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [ID_WIDTH-1:0]   r_bid;
    resp_e                 r_bresp;

    logic [AXI_ADDR_W-1:0] w_aw_next;
    logic                  w_aw_burst_err;
    logic                  w_wbeat_err;
    logic                  w_wbeat_last;
    logic                  w_wfire;
    logic [IDX_W-1:0]      w_widx;

    axi_burst_addr_gen u_aw_gen (
        .i_addr      (r_aw_addr),
        .i_size      (r_aw_size),
        .i_len       (r_aw_len),
        .i_burst     (r_aw_burst),
        .o_next_addr (w_aw_next),
        .o_burst_err (w_aw_burst_err)
    );

    assign w_wbeat_err  = !addr_ok(r_aw_addr) || (r_aw_size > 3'd2) || w_aw_burst_err;
    assign w_wbeat_last = (r_wcnt == r_aw_len);
    assign w_wfire      = (r_wstate == W_DATA) && wvalid && r_wready;
    assign w_widx       = word_idx(r_aw_addr);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wstate   <= W_IDLE;
            r_aw_id    <= '0;
            r_aw_addr  <= '0;
            r_aw_len   <= '0;
            r_aw_size  <= '0;
            r_aw_burst <= '0;
            r_wcnt     <= '0;
            r_w_err    <= 1'b0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bid      <= '0;
            r_bresp    <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (awvalid && r_awready) begin
                        r_aw_id    <= awid;
                        r_aw_addr  <= awaddr;
                        r_aw_len   <= awlen;
                        r_aw_size  <= awsize;
                        r_aw_burst <= awburst;
                        r_wcnt     <= '0;
                        r_w_err    <= 1'b0;
                        r_awready  <= 1'b0;
                        r_wready   <= 1'b1;
                        r_wstate   <= W_DATA;
                    end else begin
                        r_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_wfire) begin
                        r_aw_addr <= w_aw_next;
                        r_wcnt    <= r_wcnt + 8'd1;
                        // Either wlast or the beat count closes the burst; disagreement is a protocol error
                        if (wlast || w_wbeat_last) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bid    <= r_aw_id;
                            r_bresp  <= (r_w_err || w_wbeat_err || (wlast != w_wbeat_last))
                                        ? RESP_SLVERR : RESP_OKAY;
                            r_wstate <= W_RESP;
                        end else begin
                            r_w_err <= r_w_err | w_wbeat_err;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (w_wfire && !w_wbeat_err) begin
            for (int b = 0; b < AXI_STRB_W; b++) begin
                if (wstrb[b]) begin
                    r_mem[w_widx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bid     = r_bid;
    assign bresp   = r_bresp;

    // ------------------------------------------------------------------ read engine
    rstate_e               r_rstate;
    logic [AXI_ADDR_W-1:0] r_ar_addr;
    logic [AXI_LEN_W-1:0]  r_ar_len;
    logic [AXI_SIZE_W-1:0] r_ar_size;
    logic [1:0]            r_ar_burst;
    logic [AXI_LEN_W-1:0]  r_rcnt;
    logic                  r_arready;
    logic                  r_rvalid;
    logic                  r_rlast;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [AXI_DATA_W-1:0] r_rdata;
    resp_e                 r_rresp;

    logic [AXI_ADDR_W-1:0] w_ar_next;
    logic                  w_ar_burst_err;
    logic [AXI_ADDR_W-1:0] w_rlk_addr;
    logic [AXI_SIZE_W-1:0] w_rlk_size;
    logic                  w_rlk_burst_err;
    logic                  w_rlk_err;
    logic [AXI_DATA_W-1:0] w_rlk_data;
    logic                  w_radv;

    axi_burst_addr_gen u_ar_gen (
        .i_addr      (r_ar_addr),
        .i_size      (r_ar_size),
        .i_len       (r_ar_len),
        .i_burst     (r_ar_burst),
        .o_next_addr (w_ar_next),
        .o_burst_err (w_ar_burst_err)
    );

    // Look up the beat about to be registered: beat 0 straight off AR, later beats from the generator
    assign w_rlk_addr      = (r_rstate == R_IDLE) ? araddr : w_ar_next;
    assign w_rlk_size      = (r_rstate == R_IDLE) ? arsize : r_ar_size;
    assign w_rlk_burst_err = (r_rstate == R_IDLE) ? burst_illegal(arburst, arlen) : w_ar_burst_err;
    assign w_rlk_err       = !addr_ok(w_rlk_addr) || (w_rlk_size > 3'd2) || w_rlk_burst_err;
    assign w_rlk_data      = w_rlk_err ? '0 : r_mem[word_idx(w_rlk_addr)];
    assign w_radv          = r_rvalid && rready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rstate   <= R_IDLE;
            r_ar_addr  <= '0;
            r_ar_len   <= '0;
            r_ar_size  <= '0;
            r_ar_burst <= '0;
            r_rcnt     <= '0;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rlast    <= 1'b0;
            r_rid      <= '0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (arvalid && r_arready) begin
                        r_ar_addr  <= araddr;
                        r_ar_len   <= arlen;
                        r_ar_size  <= arsize;
                        r_ar_burst <= arburst;
                        r_rcnt     <= '0;
                        r_arready  <= 1'b0;
                        r_rvalid   <= 1'b1;
                        r_rid      <= arid;
                        r_rdata    <= w_rlk_data;
                        r_rresp    <= w_rlk_err ? RESP_SLVERR : RESP_OKAY;
                        r_rlast    <= (arlen == 8'd0);
                        r_rstate   <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (w_radv) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_ar_addr <= w_ar_next;
                            r_rcnt    <= r_rcnt + 8'd1;
                            r_rdata   <= w_rlk_data;
                            r_rresp   <= w_rlk_err ? RESP_SLVERR : RESP_OKAY;
                            r_rlast   <= ((r_rcnt + 8'd1) == r_ar_len);
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rlast   = r_rlast;
    assign rid     = r_rid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: hand-computed expectations for single, burst, wrap,
// range-error, strobe, wlast-mismatch and mid-burst reset scenarios.
module tb_axi_sram_responder;

    localparam logic [31:0] BASE  = 32'h1c00_0000;
    localparam int          DEPTH = 1024;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int checks   = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    axi_sram_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .ID_WIDTH(4)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [31:0] data [16],
                             input logic [3:0] strb, input int nbeats, input int last_beat,
                             input int bready_delay, output logic [3:0] o_bid, output logic [1:0] o_bresp,
                             output int o_held);
        int w;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        w = 0;
        while (!awready && w < 50) begin @(posedge aclk); #1; w++; end
        if (!awready) begin checks++; failures++; $display("FAIL aw_timeout addr=%h", addr); end
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            wvalid = 1'b1; wdata = data[i]; wstrb = strb; wlast = (i == last_beat);
            w = 0;
            while (!wready && w < 50) begin @(posedge aclk); #1; w++; end
            if (!wready) begin checks++; failures++; $display("FAIL w_timeout beat=%0d", i); end
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        o_held = 0;
        for (int c = 0; c < bready_delay; c++) begin
            if (bvalid) o_held++;
            @(posedge aclk); #1;
        end
        bready = 1'b1;
        w = 0;
        while (!bvalid && w < 50) begin @(posedge aclk); #1; w++; end
        if (!bvalid) begin checks++; failures++; $display("FAIL b_timeout addr=%h", addr); end
        o_bid = bid; o_bresp = bresp;
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit toggle,
                            output logic [31:0] o_data [16], output logic [1:0] o_resp [16],
                            output logic o_last [16], output logic [3:0] o_rid, output int o_beats,
                            output logic o_first, output logic o_after);
        int w;
        int cyc;
        for (int i = 0; i < 16; i++) begin
            o_data[i] = 32'hbad0_bad0; o_resp[i] = 2'b11; o_last[i] = 1'b0;
        end
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        w = 0;
        while (!arready && w < 50) begin @(posedge aclk); #1; w++; end
        if (!arready) begin checks++; failures++; $display("FAIL ar_timeout addr=%h", addr); end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        o_first = rvalid; o_beats = 0; o_rid = '0; cyc = 0;
        while (o_beats <= int'(len) && o_beats < 16 && cyc < 200) begin
            rready = toggle ? cyc[0] : 1'b1;
            if (rvalid && rready) begin
                o_data[o_beats] = rdata; o_resp[o_beats] = rresp; o_last[o_beats] = rlast;
                o_rid = rid; o_beats++;
            end
            @(posedge aclk); #1;
            cyc++;
        end
        rready = 1'b0;
        o_after = rvalid;
        if (cyc >= 200) begin checks++; failures++; $display("FAIL r_timeout addr=%h beats=%0d", addr, o_beats); end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0) begin
            failures++; $display("FAIL reset_handshake got=%b exp=000000", {awready, arready, wready, bvalid, rvalid, rlast});
        end
        checks++;
        if ({bid, rid, bresp, rresp} !== 12'h0) begin
            failures++; $display("FAIL reset_ids_resp got=%h exp=000", {bid, rid, bresp, rresp});
        end
        checks++;
        if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=00000000", rdata); end
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        checks++;
        if ({awready, arready} !== 2'b11) begin
            failures++; $display("FAIL reset_release_ready got=%b exp=11", {awready, arready});
        end
    endtask

    task automatic test_single();
        logic [31:0] d [16];
        logic [3:0] bo; logic [1:0] br; int held;
        logic [31:0] rd [16]; logic [1:0] rr [16]; logic rl [16]; logic [3:0] ro; int nb; logic fv, va;
        for (int i = 0; i < 16; i++) d[i] = 32'h0;
        d[0] = 32'hdead_beef;
        axi_write(4'h3, BASE + 32'h10, 8'd0, 3'd2, 2'b01, d, 4'hf, 1, 0, 0, bo, br, held);
        checks++;
        if ({bo, br} !== {4'h3, 2'b00}) begin failures++; $display("FAIL single_b got=%h/%0d exp=3/0", bo, br); end
        axi_read(4'h5, BASE + 32'h10, 8'd0, 3'd2, 2'b01, 1'b0, rd, rr, rl, ro, nb, fv, va);
        checks++;
        if (rd[0] !== 32'hdead_beef) begin failures++; $display("FAIL single_rdata got=%h exp=deadbeef", rd[0]); end
        checks++;
        if ({nb[4:0], rr[0], rl[0], ro} !== {5'd1, 2'b00, 1'b1, 4'h5}) begin
            failures++; $display("FAIL single_rmeta got=%0d/%0d/%0d/%h exp=1/0/1/5", nb, rr[0], rl[0], ro);
        end
        checks++;
        if ({fv, va} !== 2'b10) begin failures++; $display("FAIL single_rvalid_timing got=%b exp=10", {fv, va}); end
    endtask

    task automatic test_incr();
        logic [31:0] d [16];
        logic [3:0] bo; logic [1:0] br; int held;
        logic [31:0] rd [16]; logic [1:0] rr [16]; logic rl [16]; logic [3:0] ro; int nb; logic fv, va;
        for (int i = 0; i < 16; i++) d[i] = 32'(i + 1);
        axi_write(4'h1, BASE, 8'd3, 3'd2, 2'b01, d, 4'hf, 4, 3, 0, bo, br, held);
        checks++;
        if (br !== 2'b00) begin failures++; $display("FAIL incr_bresp got=%0d exp=0", br); end
        axi_read(4'h2, BASE, 8'd3, 3'd2, 2'b01, 1'b1, rd, rr, rl, ro, nb, fv, va);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({rd[i], rr[i], rl[i]} !== {32'(i + 1), 2'b00, (i == 3)}) begin
                failures++; $display("FAIL incr_beat%0d got=%h/%0d/%0d exp=%h/0/%0d", i, rd[i], rr[i], rl[i], i + 1, i == 3);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rd [16]; logic [1:0] rr [16]; logic rl [16]; logic [3:0] ro; int nb; logic fv, va;
        logic [31:0] exp_w [4];
        exp_w = '{32'd3, 32'd4, 32'd1, 32'd2};
        axi_read(4'h7, BASE + 32'h8, 8'd3, 3'd2, 2'b10, 1'b0, rd, rr, rl, ro, nb, fv, va);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({rd[i], rr[i]} !== {exp_w[i], 2'b00}) begin
                failures++; $display("FAIL wrap_beat%0d got=%h/%0d exp=%h/0", i, rd[i], rr[i], exp_w[i]);
            end
        end
        axi_read(4'h7, BASE + 32'h8, 8'd2, 3'd2, 2'b10, 1'b0, rd, rr, rl, ro, nb, fv, va);
        checks++;
        if (nb !== 3) begin failures++; $display("FAIL wrap_bad_count got=%0d exp=3", nb); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({rd[i], rr[i], rl[i]} !== {32'h0, 2'b10, (i == 2)}) begin
                failures++; $display("FAIL wrap_bad_beat%0d got=%h/%0d/%0d exp=0/2/%0d", i, rd[i], rr[i], rl[i], i == 2);
            end
        end
        axi_read(4'h7, BASE, 8'd0, 3'd3, 2'b01, 1'b0, rd, rr, rl, ro, nb, fv, va);
        checks++;
        if ({rd[0], rr[0]} !== {32'h0, 2'b10}) begin
            failures++; $display("FAIL size3_read got=%h/%0d exp=0/2", rd[0], rr[0]);
        end
    endtask

    task automatic test_range();
        logic [31:0] d [16];
        logic [3:0] bo; logic [1:0] br; int held;
        logic [31:0] rd [16]; logic [1:0] rr [16]; logic rl [16]; logic [3:0] ro; int nb; logic fv, va;
        for (int i = 0; i < 16; i++) d[i] = 32'h1234_5678;
        axi_write(4'h9, BASE + 32'(4 * DEPTH), 8'd0, 3'd2, 2'b01, d, 4'hf, 1, 0, 0, bo, br, held);
        checks++;
        if ({bo, br} !== {4'h9, 2'b10}) begin failures++; $display("FAIL range_bresp got=%h/%0d exp=9/2", bo, br); end
        axi_read(4'h0, BASE, 8'd0, 3'd2, 2'b01, 1'b0, rd, rr, rl, ro, nb, fv, va);
        checks++;
        if (rd[0] !== 32'd1) begin failures++; $display("FAIL range_ram_unchanged got=%h exp=00000001", rd[0]); end
        axi_read(4'h0, BASE + 32'(4 * DEPTH), 8'd0, 3'd2, 2'b01, 1'b0, rd, rr, rl, ro, nb, fv, va);
        checks++;
        if ({rd[0], rr[0]} !== {32'h0, 2'b10}) begin failures++; $display("FAIL range_read_hi got=%h/%0d exp=0/2", rd[0], rr[0]); end
        axi_read(4'h0, BASE - 32'd4, 8'd0, 3'd2, 2'b01, 1'b0, rd, rr, rl, ro, nb, fv, va);
        checks++;
        if (rr[0] !== 2'b10) begin failures++; $display("FAIL range_read_lo got=%0d exp=2", rr[0]); end
    endtask

    task automatic test_strobe();
        logic [31:0] d [16];
        logic [3:0] bo; logic [1:0] br; int held;
        logic [31:0] rd [16]; logic [1:0] rr [16]; logic rl [16]; logic [3:0] ro; int nb; logic fv, va;
        for (int i = 0; i < 16; i++) d[i] = 32'hffff_ffff;
        axi_write(4'h4, BASE + 32'h20, 8'd0, 3'd2, 2'b01, d, 4'hf, 1, 0, 0, bo, br, held);
        d[0] = 32'h1122_3344;
        axi_write(4'h6, BASE + 32'h20, 8'd0, 3'd2, 2'b01, d, 4'b0101, 1, 0, 5, bo, br, held);
        checks++;
        if (held !== 5) begin failures++; $display("FAIL strobe_bvalid_held got=%0d exp=5", held); end
        checks++;
        if ({bo, br} !== {4'h6, 2'b00}) begin failures++; $display("FAIL strobe_b got=%h/%0d exp=6/0", bo, br); end
        axi_read(4'h1, BASE + 32'h20, 8'd0, 3'd2, 2'b01, 1'b0, rd, rr, rl, ro, nb, fv, va);
        checks++;
        if (rd[0] !== 32'hff22_ff44) begin failures++; $display("FAIL strobe_rdata got=%h exp=ff22ff44", rd[0]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [16];
        logic [3:0] bo; logic [1:0] br; int held;
        logic [31:0] rd [16]; logic [1:0] rr [16]; logic rl [16]; logic [3:0] ro; int nb; logic fv, va;
        for (int i = 0; i < 16; i++) d[i] = 32'h0;
        d[0] = 32'haaaa_0001; d[1] = 32'haaaa_0002;
        axi_write(4'h2, BASE + 32'h30, 8'd1, 3'd2, 2'b00, d, 4'hf, 2, 1, 0, bo, br, held);
        checks++;
        if (br !== 2'b00) begin failures++; $display("FAIL fixed_bresp got=%0d exp=0", br); end
        axi_read(4'h2, BASE + 32'h30, 8'd0, 3'd2, 2'b01, 1'b0, rd, rr, rl, ro, nb, fv, va);
        checks++;
        if (rd[0] !== 32'haaaa_0002) begin failures++; $display("FAIL fixed_rdata got=%h exp=aaaa0002", rd[0]); end
        d[0] = 32'd7; d[1] = 32'd8;
        axi_write(4'h2, BASE + 32'h40, 8'd3, 3'd2, 2'b01, d, 4'hf, 2, 1, 0, bo, br, held);
        checks++;
        if (br !== 2'b10) begin failures++; $display("FAIL early_wlast_bresp got=%0d exp=2", br); end
        d[0] = 32'd9; d[1] = 32'd10;
        axi_write(4'h2, BASE + 32'h50, 8'd1, 3'd2, 2'b01, d, 4'hf, 2, -1, 0, bo, br, held);
        checks++;
        if (br !== 2'b10) begin failures++; $display("FAIL late_wlast_bresp got=%0d exp=2", br); end
        axi_read(4'h3, BASE + 32'h40, 8'd1, 3'd2, 2'b01, 1'b0, rd, rr, rl, ro, nb, fv, va);
        checks++;
        if ({rd[0], rd[1]} !== {32'd7, 32'd8}) begin failures++; $display("FAIL early_wlast_data got=%h,%h exp=7,8", rd[0], rd[1]); end
        axi_read(4'h3, BASE + 32'h50, 8'd1, 3'd2, 2'b01, 1'b1, rd, rr, rl, ro, nb, fv, va);
        checks++;
        if ({rd[0], rd[1]} !== {32'd9, 32'd10}) begin failures++; $display("FAIL late_wlast_data got=%h,%h exp=9,a", rd[0], rd[1]); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd [16]; logic [1:0] rr [16]; logic rl [16]; logic [3:0] ro; int nb; logic fv, va;
        int w;
        arid = 4'h2; araddr = BASE; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        w = 0;
        while (!arready && w < 50) begin @(posedge aclk); #1; w++; end
        if (!arready) begin checks++; failures++; $display("FAIL midrst_ar_timeout"); end
        @(posedge aclk); #1;
        arvalid = 1'b0; rready = 1'b1;
        repeat (3) begin @(posedge aclk); #1; end
        checks++;
        if ({rvalid, rlast, rdata} !== {1'b1, 1'b0, 32'd4}) begin
            failures++; $display("FAIL midrst_beat3 got=%0d/%0d/%h exp=1/0/4", rvalid, rlast, rdata);
        end
        aresetn = 1'b0;
        #1;
        checks++;
        if ({rvalid, rlast, arready, rdata} !== {3'b000, 32'h0}) begin
            failures++; $display("FAIL midrst_abort got=%0d/%0d/%0d/%h exp=0/0/0/0", rvalid, rlast, arready, rdata);
        end
        rready = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        axi_read(4'hc, BASE + 32'h10, 8'd0, 3'd2, 2'b01, 1'b0, rd, rr, rl, ro, nb, fv, va);
        checks++;
        if ({rd[0], rr[0], rl[0], ro} !== {32'hdead_beef, 2'b00, 1'b1, 4'hc}) begin
            failures++; $display("FAIL midrst_after got=%h/%0d/%0d/%h exp=deadbeef/0/1/c", rd[0], rr[0], rl[0], ro);
        end
    endtask

    initial begin
        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        awlock = 1'b0; awcache = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
        arlock = 1'b0; arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        test_reset();
        test_single();
        test_incr();
        test_wrap();
        test_range();
        test_strobe();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
